// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: word/address types, FSM states,
// queue entry layout and word alignment helper.
package fetch_unit_pkg;

    localparam int INST_BYTES = 4;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        word_t inst;
    } q_entry_t;

    function automatic addr_t align_word(input addr_t a);
        return a & ~addr_t'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instruction} pairs feeding decode; head is read
// combinationally from storage, flush empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_push,
    input  logic [31:0]           i_push_pc,
    input  logic [31:0]           i_push_inst,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [31:0]           o_head_pc,
    output logic [31:0]           o_head_inst,
    output logic [$clog2(DEPTH):0] o_count
);
    import fetch_unit_pkg::*;

    localparam int PW = $clog2(DEPTH);

    q_entry_t    r_mem [DEPTH];
    logic [PW:0] r_wr;
    logic [PW:0] r_rd;
    q_entry_t    w_head;

    always_ff @(posedge clk_in) begin
        if (rst_in || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage carries data only; occupancy is tracked by the pointers above.
    always_ff @(posedge clk_in) begin
        if (i_push && !i_flush)
            r_mem[r_wr[PW-1:0]] <= '{pc: i_push_pc, inst: i_push_inst};
    end

    assign w_head      = r_mem[r_rd[PW-1:0]];
    assign o_count     = r_wr - r_rd;
    assign o_valid     = (o_count != '0);
    assign o_head_pc   = w_head.pc;
    assign o_head_inst = w_head.inst;

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch requester with credit-limited issue, redirect
// flushing and stale-response dropping. Optional counters: FETCH_UNIT_STATS_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 4,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        fetch_request_valid_out,
    input  logic        fetch_request_ready_in,
    output logic [31:0] fetch_request_address_out,
    input  logic        fetch_response_valid_in,
    output logic        fetch_response_ready_out,
    input  logic [31:0] fetch_response_data_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        halt_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_data_out,
    output logic [31:0] inst_pc_out
`ifdef FETCH_UNIT_STATS_EN
    ,
    output logic [31:0] stat_issued_out,
    output logic [31:0] stat_dropped_out,
    output logic [31:0] stat_stall_cycles_out
`endif
);
    import fetch_unit_pkg::*;

    localparam int QW = $clog2(QUEUE_DEPTH) + 1;
    localparam int CW = QW + 1;

    addr_t        r_pc;
    addr_t        r_req_addr;
    addr_t        r_resp_pc;
    logic         r_req_valid;
    logic         r_resp_ready;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    fetch_state_t r_state;

    logic          w_acc, w_hold, w_resp, w_push, w_pop, w_flush, w_issue;
    logic          w_q_valid;
    logic [QW-1:0] w_q_count;
    logic [CW-1:0] w_inflight_nxt, w_count_nxt, w_drop_nxt;
    addr_t         w_base_pc;

    assign w_acc   = r_req_valid & fetch_request_ready_in;
    assign w_hold  = r_req_valid & ~fetch_request_ready_in;
    assign w_resp  = fetch_response_valid_in & r_resp_ready;
    assign w_flush = redirect_valid_in;
    assign w_pop   = w_q_valid & inst_ready_in;
    assign w_push  = w_resp && (r_drop == '0) && !redirect_valid_in;

    assign w_inflight_nxt = r_inflight + CW'(w_acc) - CW'(w_resp);
    assign w_count_nxt    = w_flush ? '0 : CW'(w_q_count) + CW'(w_push) - CW'(w_pop);

    // Everything still owed for the old path is dropped, including a held
    // request that has not been accepted yet.
    assign w_drop_nxt = redirect_valid_in ? (w_inflight_nxt + CW'(w_hold))
                      : (w_resp && r_drop != '0) ? (r_drop - 1'b1)
                      : r_drop;

    assign w_base_pc = redirect_valid_in ? align_word(redirect_pc_in) : r_pc;

    assign w_issue = !w_hold && !halt_in && (r_state != HALTED)
                  && (w_inflight_nxt < CW'(MAX_INFLIGHT))
                  && ((w_inflight_nxt + w_count_nxt) < CW'(QUEUE_DEPTH));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc         <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_inflight   <= '0;
            r_drop       <= '0;
            r_state      <= FETCH;
        end else begin
            r_resp_ready <= 1'b1;
            r_inflight   <= w_inflight_nxt;
            r_drop       <= w_drop_nxt;

            if (w_hold) begin
                r_req_valid <= 1'b1;
                r_pc        <= w_base_pc;
            end else if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= w_base_pc;
                r_pc        <= w_base_pc + addr_t'(INST_BYTES);
            end else begin
                r_req_valid <= 1'b0;
                r_pc        <= w_base_pc;
            end

            // First surviving response after a redirect belongs to the target.
            if (redirect_valid_in)
                r_resp_pc <= align_word(redirect_pc_in);
            else if (w_push)
                r_resp_pc <= r_resp_pc + addr_t'(INST_BYTES);

            if (halt_in && !w_hold)
                r_state <= HALTED;
            else if (w_drop_nxt != '0)
                r_state <= DRAIN;
            else
                r_state <= FETCH;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_push      (w_push),
        .i_push_pc   (r_resp_pc),
        .i_push_inst (fetch_response_data_in),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_valid     (w_q_valid),
        .o_head_pc   (inst_pc_out),
        .o_head_inst (inst_data_out),
        .o_count     (w_q_count)
    );

    assign fetch_request_valid_out   = r_req_valid;
    assign fetch_request_address_out = r_req_addr;
    assign fetch_response_ready_out  = r_resp_ready;
    assign inst_valid_out            = w_q_valid;

`ifdef FETCH_UNIT_STATS_EN
    word_t r_stat_issued, r_stat_dropped, r_stat_stall;

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stat_issued  <= '0;
            r_stat_dropped <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_acc)            r_stat_issued  <= sat_inc(r_stat_issued);
            if (w_resp && !w_push) r_stat_dropped <= sat_inc(r_stat_dropped);
            if (w_hold)           r_stat_stall   <= sat_inc(r_stat_stall);
        end
    end

    assign stat_issued_out       = r_stat_issued;
    assign stat_dropped_out      = r_stat_dropped;
    assign stat_stall_cycles_out = r_stat_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model answers requests,
// and a path model predicts request addresses and the pc/instruction stream at decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int QD = 4;
    localparam int MI = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        fetch_request_valid_out;
    logic        fetch_request_ready_in = 1'b0;
    logic [31:0] fetch_request_address_out;
    logic        fetch_response_valid_in = 1'b0;
    logic        fetch_response_ready_out;
    logic [31:0] fetch_response_data_in = '0;
    logic        redirect_valid_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        halt_in = 1'b0;
    logic        inst_valid_out;
    logic        inst_ready_in = 1'b0;
    logic [31:0] inst_data_out;
    logic [31:0] inst_pc_out;
`ifdef FETCH_UNIT_STATS_EN
    logic [31:0] stat_issued_out, stat_dropped_out, stat_stall_cycles_out;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QD), .MAX_INFLIGHT(MI)) dut (
        .clk_in                    (clk_in),
        .rst_in                    (rst_in),
        .fetch_request_valid_out   (fetch_request_valid_out),
        .fetch_request_ready_in    (fetch_request_ready_in),
        .fetch_request_address_out (fetch_request_address_out),
        .fetch_response_valid_in   (fetch_response_valid_in),
        .fetch_response_ready_out  (fetch_response_ready_out),
        .fetch_response_data_in    (fetch_response_data_in),
        .redirect_valid_in         (redirect_valid_in),
        .redirect_pc_in            (redirect_pc_in),
        .halt_in                   (halt_in),
        .inst_valid_out            (inst_valid_out),
        .inst_ready_in             (inst_ready_in),
        .inst_data_out             (inst_data_out),
        .inst_pc_out               (inst_pc_out)
`ifdef FETCH_UNIT_STATS_EN
        ,
        .stat_issued_out           (stat_issued_out),
        .stat_dropped_out          (stat_dropped_out),
        .stat_stall_cycles_out     (stat_stall_cycles_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Memory model: addresses accepted and not yet answered, in order.
    logic [31:0] mmu_q[$];

    // Path model: next expected request address and next expected decode pc.
    logic [31:0] m_next_addr, m_dec_pc, m_hold_addr;
    bit          m_hold_ok;

    // Observations and expectations of the current cycle.
    bit          ev_acc, ev_pop, ev_held;
    logic [31:0] ev_addr, ev_pc, ev_data, exp_addr, exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_reset();
        mmu_q.delete();
        m_next_addr = RESET_PC;
        m_dec_pc    = RESET_PC;
        m_hold_ok   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        fetch_request_ready_in  = 1'b0;
        fetch_response_valid_in = 1'b0;
        inst_ready_in     = 1'b0;
        redirect_valid_in = 1'b0;
        halt_in           = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, answer from the memory model, record events, advance the model.
    task automatic cycle(input bit rdy, input bit irdy, input bit redir,
                         input logic [31:0] rpc, input int resp_pct);
        @(negedge clk_in);
        fetch_request_ready_in = rdy;
        inst_ready_in          = irdy;
        redirect_valid_in      = redir;
        redirect_pc_in         = rpc;
        if (mmu_q.size() > 0 && fetch_response_ready_out && $urandom_range(99) < resp_pct) begin
            fetch_response_valid_in = 1'b1;
            fetch_response_data_in  = mem_word(mmu_q.pop_front());
        end else begin
            fetch_response_valid_in = 1'b0;
            fetch_response_data_in  = $urandom;
        end
        #1;
        ev_acc   = fetch_request_valid_out && rdy;
        ev_held  = fetch_request_valid_out && !rdy;
        ev_addr  = fetch_request_address_out;
        ev_pop   = inst_valid_out && irdy;
        ev_pc    = inst_pc_out;
        ev_data  = inst_data_out;
        exp_addr = m_hold_ok ? m_hold_addr : m_next_addr;
        exp_pc   = m_dec_pc;
        if (ev_acc) begin
            mmu_q.push_back(ev_addr);
            if (m_hold_ok) m_hold_ok = 0;
            else           m_next_addr = m_next_addr + 32'd4;
        end
        if (ev_pop) m_dec_pc = m_dec_pc + 32'd4;
        if (redir) begin
            m_hold_ok   = ev_held;
            m_hold_addr = ev_addr;
            m_next_addr = {rpc[31:2], 2'b00};
            m_dec_pc    = m_next_addr;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        checks++;
        if (fetch_request_valid_out !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", fetch_request_valid_out); end
        checks++;
        if (fetch_response_ready_out !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %b expected 0", fetch_response_ready_out); end
        checks++;
        if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_out); end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        cycle(1, 0, 0, '0, 0);
        checks++;
        if (!ev_acc || ev_addr !== RESET_PC) begin errors++; $display("FAIL reset_first_req: got valid %b addr %h expected 1 %h", ev_acc, ev_addr, RESET_PC); end
        checks++;
        if (fetch_response_ready_out !== 1'b1) begin errors++; $display("FAIL reset_resp_ready_after: got %b expected 1", fetch_response_ready_out); end
    endtask

    task automatic test_stream();
        int pops;
        pops = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_acc) begin
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h expected %h", ev_addr, exp_addr); end
            end
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL stream_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
            if (i >= 10 && ev_pop) pops++;
        end
        checks++;
        if (pops != 30) begin errors++; $display("FAIL stream_no_bubbles: got %0d pops expected 30", pops); end
    endtask

    task automatic test_queue_full();
        int accepts;
        accepts = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, '0, 100);
            if (ev_acc) begin
                accepts++;
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL full_addr: got %h expected %h", ev_addr, exp_addr); end
            end
            if (i >= 12) begin
                checks++;
                if (fetch_request_valid_out !== 1'b0) begin errors++; $display("FAIL full_valid_low: got %b expected 0 at cycle %0d", fetch_request_valid_out, i); end
            end
        end
        checks++;
        if (accepts != QD) begin errors++; $display("FAIL full_accept_count: got %0d expected %0d", accepts, QD); end
        for (int i = 0; i < 15; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_acc) begin
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL full_drain_addr: got %h expected %h", ev_addr, exp_addr); end
            end
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL full_drain_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset();
        held = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, '0, 100);
            if (i == 0) held = ev_addr;
            checks++;
            if (fetch_request_valid_out !== 1'b1 || ev_addr !== held) begin errors++; $display("FAIL stall_hold: got valid %b addr %h expected 1 %h", fetch_request_valid_out, ev_addr, held); end
        end
        cycle(1, 1, 0, '0, 100);
        checks++;
        if (!ev_acc || ev_addr !== exp_addr) begin errors++; $display("FAIL stall_accept: got acc %b addr %h expected 1 %h", ev_acc, ev_addr, exp_addr); end
        cycle(0, 1, 0, '0, 100);
        checks++;
        if (fetch_request_valid_out !== 1'b1 || ev_addr !== held + 32'd4) begin errors++; $display("FAIL stall_next_addr: got valid %b addr %h expected 1 %h", fetch_request_valid_out, ev_addr, held + 32'd4); end
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL stall_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_redirect_drop();
        int  accepts;
        bit  seen;
        accepts = 0;
        seen    = 0;
        do_reset();
        for (int i = 0; i < 10 && accepts < 2; i++) begin
            cycle(1, 0, 0, '0, 0);
            if (ev_acc) accepts++;
        end
        checks++;
        if (accepts != 2) begin errors++; $display("FAIL redir_two_inflight: got %0d accepts expected 2", accepts); end
        cycle(1, 0, 1, 32'h0000_0100, 0);
        checks++;
        if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL redir_queue_before: got %b expected 0", inst_valid_out); end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1, 0, 0, '0, 100);
            if (ev_acc) begin
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL redir_addr: got %h expected %h", ev_addr, exp_addr); end
            end
            if (inst_valid_out) begin
                seen = 1;
                checks++;
                if (inst_pc_out !== 32'h0000_0100 || inst_data_out !== mem_word(32'h0000_0100)) begin errors++; $display("FAIL redir_first_inst: got pc %h data %h expected pc 00000100 data %h", inst_pc_out, inst_data_out, mem_word(32'h0000_0100)); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL redir_timeout: got no instruction expected pc 00000100"); end
        for (int i = 0; i < 15; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL redir_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_redirect_collide();
        int          collisions;
        bit          rdy, irdy, redir;
        int          pct;
        logic [31:0] tgt;
        collisions = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk_in);
            #1;
            rdy   = ($urandom_range(3) != 0);
            irdy  = ($urandom_range(2) != 0);
            pct   = 70;
            tgt   = {20'h0, 12'($urandom)};
            redir = ($urandom_range(19) == 0);
            if (fetch_request_valid_out && mmu_q.size() > 0 && $urandom_range(5) == 0) begin
                rdy = 1; redir = 1; pct = 100;
                collisions++;
            end
            cycle(rdy, irdy, redir, tgt, pct);
            if (ev_acc) begin
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL collide_addr: got %h expected %h", ev_addr, exp_addr); end
            end
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL collide_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
        checks++;
        if (collisions == 0) begin errors++; $display("FAIL collide_coverage: got 0 collisions expected >0"); end
    endtask

    task automatic test_wrap_halt();
        bit          wrap_seen, resumed;
        logic [31:0] prev;
        int          late_acc;
        wrap_seen = 0;
        resumed   = 0;
        late_acc  = 0;
        prev      = '1;
        do_reset();
        cycle(0, 1, 1, 32'hFFFF_FFF8, 100);
        for (int i = 0; i < 15 && !wrap_seen; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_acc) begin
                checks++;
                if (ev_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr: got %h expected %h", ev_addr, exp_addr); end
                if (ev_addr == 32'h0 && prev == 32'hFFFF_FFFC) wrap_seen = 1;
                prev = ev_addr;
            end
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL wrap_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
        checks++;
        if (!wrap_seen) begin errors++; $display("FAIL wrap_seen: got no 00000000 after fffffffc expected wrap"); end
        halt_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_acc && i >= 1) late_acc++;
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL halt_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
        checks++;
        if (late_acc != 0 || fetch_request_valid_out !== 1'b0) begin errors++; $display("FAIL halt_no_issue: got %0d accepts valid %b expected 0 0", late_acc, fetch_request_valid_out); end
        checks++;
        if (mmu_q.size() != 0 || m_dec_pc !== m_next_addr || inst_valid_out !== 1'b0) begin errors++; $display("FAIL halt_owed_delivered: got decode pc %h pending %0d expected %h 0", m_dec_pc, mmu_q.size(), m_next_addr); end
        cycle(1, 1, 1, 32'h0000_0202, 100);
        cycle(1, 1, 0, '0, 100);
        checks++;
        if (fetch_request_valid_out !== 1'b0) begin errors++; $display("FAIL halt_redirect_stays: got valid %b expected 0", fetch_request_valid_out); end
        halt_in = 1'b0;
        for (int i = 0; i < 10 && !resumed; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_acc) begin
                resumed = 1;
                checks++;
                if (ev_addr !== 32'h0000_0200) begin errors++; $display("FAIL halt_resume_addr: got %h expected 00000200", ev_addr); end
            end
        end
        checks++;
        if (!resumed) begin errors++; $display("FAIL halt_resume_timeout: got no request expected 00000200"); end
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, '0, 100);
            if (ev_pop) begin
                checks++;
                if (ev_pc !== exp_pc || ev_data !== mem_word(exp_pc)) begin errors++; $display("FAIL resume_inst: got pc %h data %h expected pc %h data %h", ev_pc, ev_data, exp_pc, mem_word(exp_pc)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_queue_full();
        test_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
